onehot_decoder_seq: RTL
=======================

# onehot_decoder_seq

Sequenced 3-to-8 decoder, the receive-side counterpart of the team's 8-to-3 encoder. It accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a one-hot strobe on an 8-bit bus, held for a programmable number of cycles, followed by one idle cycle. It sits between code producers (encoder outputs, control sequencers) and one-hot consumers such as LED banks, mux selects and chip-select lines.

## Interface
- HOLD, default 4: cycles each one-hot value is driven; legal range 1..255.
- DEPTH, default 4: code FIFO depth; power of two, ≥2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- code  input  3  code to decode; bit mapping is the exact inverse of the encoder.
- code_valid  input  1  code is valid this cycle.
- code_ready  output  1  FIFO can accept; equals !full.
- y  output  8  registered one-hot strobe; all-zero when not driving.
- busy  output  1  high when in DRIVE or GAP, or when the FIFO is non-empty.

Clock, reset polarity and reset synchronicity are decided: one clock; reset is asynchronous and active-low.

## Operation
- Decode mapping: index k = {code[0], code[1], code[2]}, and y = 1 << k.
  - 3'b111 → 8'b1000_0000.
  - 3'b101 → 8'b0010_0000.
  - 3'b010 → 8'b0000_0100.
  - 3'b001 → 8'b0001_0000.
  - 3'b000 → 8'b0000_0001.
- Push: a code is written on any edge where code_valid && code_ready. Codes are not decoded at push time.
- FSM states:
  - IDLE: y=0. If the FIFO is non-empty: pop, load y with the decoded value, load hcnt=HOLD-1, go to DRIVE.
  - DRIVE: hold y. If hcnt≠0, decrement it. If hcnt==0, set y=0 and go to GAP.
  - GAP: y=0 for exactly one cycle. If the FIFO is non-empty: pop, load y and hcnt, go to DRIVE. Otherwise go to IDLE.
- Steady output pattern: HOLD cycles one-hot, then 1 cycle zero, repeating.
- Simultaneous push and pop: the count is unchanged and both operations take effect.
- Push while full: impossible, because code_ready is low when full. A code_valid held high while full is held off by the producer, not dropped.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset values:
  - y=0, busy=0, state=IDLE, hcnt=0.
  - FIFO empty, so code_ready=1.
- Reset mid-strobe: y drops to 0 asynchronously and all queued codes are discarded.

## Timing
- Latency: a code accepted at edge E into an empty, IDLE block drives y from edge E+1.
- y stays high through edge E+HOLD and returns to 0 at edge E+HOLD+1.
- Back-to-back spacing: the next code's y rises HOLD+1 edges after the previous y rose.
- code_ready is combinational from the FIFO count. It has no path from code_valid.
- With HOLD=1, the pattern is 1 cycle on, 1 cycle off.

## Configuration
- DEC_FLUSH_EN defined: adds input port flush (1 bit, synchronous, active-high). When high at an edge:
  - FIFO emptied;
  - y forced to 0;
  - FSM forced to IDLE.
  A push on the same edge as flush is discarded, and code_ready remains 1 afterwards.
- DEC_FLUSH_EN undefined: the port is absent and only rst_n clears state.

## Structure
- Shared package onehot_dec_pkg holds:
  - state enum IDLE/DRIVE/GAP;
  - function decode3to8 implementing the bit-reversed mapping;
  - the width constant CODE_W=3.
- Sub-module code_fifo holds storage, pointers, count, full and empty. It is parameterised by DEPTH and width.
- The top level holds the FSM, hcnt and the y register.

## Test plan
- Reset, then push 3'b111 with HOLD=4. Required: y=8'h80 for 4 cycles starting 1 cycle after the accept, then 8'h00. busy falls after the GAP cycle.
- Push 3'b101, 3'b010 and 3'b001 back-to-back. Required: y=8'h20×4, 00, 8'h04×4, 00, 8'h10×4, 00.
- Fill with 4 codes while the first is still driving. Required:
  - code_ready=0 after the 4th accept;
  - the held code_valid is accepted on the edge the first pop frees a slot;
  - no code is lost or reordered.
- Assert rst_n low 2 cycles into a strobe with 3 codes queued. Required: y=0 immediately, code_ready=1, busy=0, and no strobe after reset release.
- HOLD=1 with 8 consecutive codes 0..7. Required: alternating one-hot and zero cycles, with index values 0,4,2,6,1,5,3,7.
- With DEC_FLUSH_EN defined, pulse flush mid-DRIVE with 2 codes queued and code_valid high on that edge. Required: y=0 next cycle, FIFO empty, the same-edge push discarded, and state IDLE.

Source files
------------

// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg
// Shared definitions for the sequenced 3-to-8 one-hot decoder:
//   - CODE_W / ONEHOT_W : code and strobe widths
//   - dec_state_e       : IDLE / DRIVE / GAP sequencer states
//   - decode3to8()      : bit-reversed code-to-one-hot mapping, the exact
//                         inverse of the team's 8-to-3 encoder
`timescale 1ns/1ps

package onehot_dec_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_e;

  // The encoder emits the one-hot index LSB-first on code[2:0], so the
  // index is recovered by reversing the code bits before shifting.
  function automatic logic [ONEHOT_W-1:0] decode3to8(input logic [CODE_W-1:0] code_in);
    logic [CODE_W-1:0] idx;
    idx        = {code_in[0], code_in[1], code_in[2]};
    decode3to8 = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// code_fifo
// Small synchronous FIFO holding raw codes for the decoder sequencer.
// Show-ahead read: rd_data always presents the oldest entry.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear; a push on the same edge is discarded
//   push/wr_data: write request and data (ignored when full)
//   pop         : read request (ignored when empty)
//   rd_data     : oldest entry
//   full, empty : occupancy flags
//   count       : number of stored entries (log2(DEPTH)+1 bits)
`timescale 1ns/1ps

module code_fifo
  import onehot_dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CODE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full && !flush;
  assign pop_ok_s  = pop && !empty && !flush;

  // Storage array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq
// Sequenced 3-to-8 decoder. Codes arrive over a valid/ready handshake,
// are queued in code_fifo, and each is replayed as a one-hot strobe on y
// for HOLD cycles followed by one all-zero cycle.
// Parameters:
//   HOLD  : cycles each one-hot value is driven (1..255)
//   DEPTH : code FIFO depth (power of two, >= 2)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   code       : 3-bit code (bit-reversed index)
//   code_valid : code present this cycle
//   code_ready : FIFO not full (combinational from FIFO count only)
//   y          : registered one-hot strobe, zero when not driving
//   busy       : registered; high in DRIVE/GAP or while codes are queued
//   flush      : present only when DEC_FLUSH_EN is defined; synchronous
//                active-high clear of FIFO, strobe and sequencer
`timescale 1ns/1ps

module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CODE_W-1:0]   code,
  input  logic                code_valid,
  output logic                code_ready,
  output logic [ONEHOT_W-1:0] y,
  output logic                busy
`ifdef DEC_FLUSH_EN
  ,
  input  logic                flush
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    HOLD_M1 = 8'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic                flush_s;
  logic                push_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CW-1:0]       fifo_count_s;
  logic [CODE_W-1:0]   fifo_data_s;
  logic [CW-1:0]       count_next_s;

  dec_state_e          state_r;
  dec_state_e          state_next_s;
  logic [ONEHOT_W-1:0] y_r;
  logic [ONEHOT_W-1:0] y_next_s;
  logic [7:0]          hcnt_r;
  logic [7:0]          hcnt_next_s;
  logic                busy_r;
  logic                busy_next_s;

`ifdef DEC_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign code_ready = !fifo_full_s;
  assign push_s     = code_valid && !fifo_full_s;
  assign y          = y_r;
  assign busy       = busy_r;

  code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush_s),
    .push    (push_s),
    .wr_data (code),
    .pop     (pop_s),
    .rd_data (fifo_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Sequencer next-state, strobe and hold-counter logic.
  always_comb begin
    state_next_s = state_r;
    y_next_s     = y_r;
    hcnt_next_s  = hcnt_r;
    pop_s        = 1'b0;
    if (flush_s) begin
      state_next_s = IDLE;
      y_next_s     = 8'h00;
      hcnt_next_s  = 8'd0;
    end else begin
      case (state_r)
        // IDLE and GAP both launch the next queued code; GAP falls back
        // to IDLE when nothing is waiting.
        IDLE, GAP: begin
          if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            y_next_s     = decode3to8(fifo_data_s);
            hcnt_next_s  = HOLD_M1;
            state_next_s = DRIVE;
          end else begin
            y_next_s     = 8'h00;
            state_next_s = IDLE;
          end
        end
        DRIVE: begin
          if (hcnt_r != 8'd0) begin
            hcnt_next_s = hcnt_r - 8'd1;
          end else begin
            y_next_s     = 8'h00;
            state_next_s = GAP;
          end
        end
        default: begin
          state_next_s = IDLE;
          y_next_s     = 8'h00;
          hcnt_next_s  = 8'd0;
        end
      endcase
    end
  end

  // Post-edge FIFO occupancy, so busy can be registered without lagging.
  always_comb begin
    count_next_s = fifo_count_s;
    if (flush_s) begin
      count_next_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = fifo_count_s + CNT_ONE;
        2'b01:   count_next_s = fifo_count_s - CNT_ONE;
        default: count_next_s = fifo_count_s;
      endcase
    end
    busy_next_s = (state_next_s != IDLE) || (count_next_s != {CW{1'b0}});
  end

  // Sequencer state, strobe, hold counter and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      y_r     <= 8'h00;
      hcnt_r  <= 8'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      y_r     <= y_next_s;
      hcnt_r  <= hcnt_next_s;
      busy_r  <= busy_next_s;
    end
  end

endmodule
